// File: rtl/apu_pkg.sv
// apu_pkg: shared APU frame-sequencer constants, event encoding and step event table.
package apu_pkg;

    localparam logic MODE_4STEP = 1'b0;
    localparam logic MODE_5STEP = 1'b1;
    localparam int   MODE_BIT   = 7;
    localparam int   INH_BIT    = 6;

    localparam logic [2:0] STEP_LAST_4 = 3'd3;
    localparam logic [2:0] STEP_LAST_5 = 3'd4;

    typedef struct packed {
        logic q;
        logic h;
        logic irq;
    } seq_evt_t;

    // Events fired by a tick, indexed by the step value at the tick
    function automatic seq_evt_t seq_event(input logic mode, input logic [2:0] s);
        case ({mode, s})
            {MODE_4STEP, 3'd0}, {MODE_4STEP, 3'd2},
            {MODE_5STEP, 3'd0}, {MODE_5STEP, 3'd2}: return seq_evt_t'(3'b100);
            {MODE_4STEP, 3'd1}, {MODE_5STEP, 3'd1},
            {MODE_5STEP, 3'd4}:                     return seq_evt_t'(3'b110);
            {MODE_4STEP, 3'd3}:                     return seq_evt_t'(3'b111);
            default:                                return seq_evt_t'(3'b000);
        endcase
    endfunction

endpackage

// File: rtl/apu_prescaler.sv
// apu_prescaler: modulo-N counter with synchronous clear and a tick on the last count.
module apu_prescaler #(
    parameter int N = 3729,
    parameter int W = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    assign tick = count == LAST;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else
            count <= (clr || tick) ? '0 : count + 1'b1;

endmodule

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: divides apu_clk into quarter/half-frame strobes, owns the
// frame-counter register and raises the frame IRQ.
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int STEP_LEN = 3729,
    parameter int CNT_W    = 12
) (
    input  logic       apu_clk,
    input  logic       rst,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_data,
    input  logic       irq_ack,
    output logic       qtr_clk,
    output logic       hlf_clk,
    output logic       irq,
    output logic [2:0] step
);

    logic     mode;
    logic     inh;
    logic     tick;
    logic     adv;
    logic     wr_5step;
    logic     wr_inh;
    logic [2:0] step_nxt;
    seq_evt_t ev;

    apu_prescaler #(.N(STEP_LEN), .W(CNT_W)) u_prescaler (
        .clk (apu_clk),
        .rst (rst),
        .clr (cfg_wr),
        .tick(tick)
    );

    // A register write restarts the frame, so it swallows a coincident tick
    assign adv      = tick & ~cfg_wr;
    assign ev       = seq_event(mode, step);
    assign wr_5step = cfg_data[MODE_BIT] == MODE_5STEP;
    assign wr_inh   = cfg_data[INH_BIT];

    always_comb
        step_nxt = (step >= (mode == MODE_5STEP ? STEP_LAST_5 : STEP_LAST_4)) ? 3'd0 : step + 3'd1;

    always_ff @(posedge apu_clk or posedge rst)
        if (rst) begin
            mode    <= MODE_4STEP;
            inh     <= 1'b0;
            step    <= 3'd0;
            qtr_clk <= 1'b0;
            hlf_clk <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (cfg_wr) begin
                mode <= cfg_data[MODE_BIT];
                inh  <= wr_inh;
            end
            step    <= (cfg_wr || step > STEP_LAST_5) ? 3'd0 : adv ? step_nxt : step;
            qtr_clk <= cfg_wr ? wr_5step : adv & ev.q;
            hlf_clk <= cfg_wr ? wr_5step : adv & ev.h;
            irq     <= (adv & ev.irq & (mode == MODE_4STEP) & ~inh)
                     | (irq & ~irq_ack & ~(cfg_wr & wr_inh));
        end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer: randomized scoreboard bench with a cycles-since-restart reference model.
module tb_apu_frame_sequencer;

    localparam int L = 4;

    logic       apu_clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       irq_ack = 1'b0;
    logic       qtr_clk;
    logic       hlf_clk;
    logic       irq;
    logic [2:0] step;

    apu_frame_sequencer #(.STEP_LEN(L), .CNT_W(2)) dut (
        .apu_clk (apu_clk),
        .rst     (rst),
        .cfg_wr  (cfg_wr),
        .cfg_data(cfg_data),
        .irq_ack (irq_ack),
        .qtr_clk (qtr_clk),
        .hlf_clk (hlf_clk),
        .irq     (irq),
        .step    (step)
    );

    always #5 apu_clk = ~apu_clk;

    typedef struct packed {
        logic       q;
        logic       h;
        logic       i;
        logic [2:0] s;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0;
    int   passes = 0;

    // Model state: cycles since the last restart, plus the register contents
    int   m_t = 0;
    int   ms;
    bit   mtk;
    logic m_mode = 1'b0;
    logic m_inh = 1'b0;
    logic m_irq = 1'b0;
    logic m_q = 1'b0;
    logic m_h = 1'b0;

    function automatic int nsteps(input logic md);
        return md ? 5 : 4;
    endfunction

    function automatic logic f_q(input logic md, input int s);
        return md ? (s != 3) : 1'b1;
    endfunction

    function automatic logic f_h(input logic md, input int s);
        return md ? (s == 1 || s == 4) : (s == 1 || s == 3);
    endfunction

    function automatic logic f_i(input logic md, input int s);
        return !md && s == 3;
    endfunction

    initial forever begin
        @(posedge apu_clk);
        if (rst) begin
            m_t = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_q = 0; m_h = 0;
        end else begin
            ms  = (m_t / L) % nsteps(m_mode);
            mtk = (m_t % L == L - 1) && !cfg_wr;
            if (cfg_wr) begin
                m_mode = cfg_data[7];
                m_inh  = cfg_data[6];
                m_t    = 0;
                m_q    = cfg_data[7];
                m_h    = cfg_data[7];
                m_irq  = m_irq && !irq_ack && !cfg_data[6];
            end else begin
                m_q   = mtk && f_q(m_mode, ms);
                m_h   = mtk && f_h(m_mode, ms);
                m_irq = (mtk && f_i(m_mode, ms) && !m_inh) || (m_irq && !irq_ack);
                m_t++;
            end
        end
        sb.push_back({m_q, m_h, m_irq, 3'((m_t / L) % nsteps(m_mode))});
    end

    initial forever begin
        @(negedge apu_clk);
        if (sb.size() > 0) begin
            me = sb.pop_front();
            if (rst) me = '0;
            checks++;
            if ({qtr_clk, hlf_clk, irq, step} === me)
                passes++;
            else
                $display("FAIL cycle t=%0t got q=%b h=%b irq=%b step=%0d expected q=%b h=%b irq=%b step=%0d",
                         $time, qtr_clk, hlf_clk, irq, step, me.q, me.h, me.i, me.s);
        end
    end

    task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got %b expected %b", nm, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge apu_clk);
    endtask

    task automatic wr(input logic [7:0] d);
        cfg_wr = 1'b1;
        cfg_data = d;
        @(negedge apu_clk);
        cfg_wr = 1'b0;
    endtask

    task automatic wait_for(input int s, input int p);
        for (int i = 0; i < 200; i++) begin
            if (m_t % L == p && (m_t / L) % nsteps(m_mode) == s) return;
            @(negedge apu_clk);
        end
        checks++;
        $display("FAIL wait_phase step=%0d phase=%0d not reached within 200 cycles", s, p);
    endtask

    task automatic wait_irq();
        for (int i = 0; i < 200; i++) begin
            if (m_irq) return;
            @(negedge apu_clk);
        end
        checks++;
        $display("FAIL wait_irq irq not expected within 200 cycles");
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 200; i++) begin
            if (m_q) return;
            @(negedge apu_clk);
        end
        checks++;
        $display("FAIL wait_strobe no strobe expected within 200 cycles");
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(34);
        wr(8'h80);
        cyc(30);
        wr(8'h00);
        wait_irq();
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        cyc(2);
        wr(8'h40);
        cyc(3 * 4 * L);
        wr(8'h00);
        wait_for(3, L - 1);
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        chk("ack_vs_set", {5'd0, irq}, 6'd1);
        cyc(4);
        wait_for(1, L - 1);
        wr(8'h00);
        chk("wr_on_tick", {qtr_clk, hlf_clk, 1'b0, step}, 6'd0);
        cyc(10);
        wr(8'h80);
        wr(8'h00);
        cyc(20);
        wr(8'h00);
        cyc($urandom_range(0, 5));
        wait_strobe();
        #2 rst = 1'b1;
        #1 chk("reset_async", {qtr_clk, hlf_clk, irq, step}, 6'd0);
        cyc(2);
        rst = 1'b0;
        cyc(34);
        for (int i = 0; i < 400; i++) begin
            cfg_wr   = $urandom_range(0, 19) == 0;
            cfg_data = 8'($urandom);
            irq_ack  = $urandom_range(0, 7) == 0;
            @(negedge apu_clk);
        end
        cfg_wr = 1'b0;
        irq_ack = 1'b0;
        cyc(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
